// File: rtl/blake2_bus_pkg.sv
// Shared constants, FSM encoding and control-word helper for the host end
// of the parallel hashing bus.
package blake2_bus_pkg;

  localparam int CTRL_VALID = 0;
  localparam int CTRL_START = 1;
  localparam int CTRL_LAST  = 2;

  localparam int HASH_CTRL_READY = 0;
  localparam int HASH_CTRL_V     = 1;

  localparam int BLAKE2S_HASH_BYTES = 32;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    GAP       = 3'd2,
    ARM       = 3'd3,
    WAIT_HASH = 3'd4
  } state_t;

  function automatic logic [2:0] make_ctrl(input logic start, input logic last);
    logic [2:0] c;
    c             = '0;
    c[CTRL_VALID] = 1'b1;
    c[CTRL_START] = start;
    c[CTRL_LAST]  = last;
    return c;
  endfunction

endpackage

// File: rtl/blake2_bus_host_if.sv
// Local byte streams plus the Pmod bus pins of the host, bundled as one port.
interface blake2_bus_host_if;
  logic [7:0] msg_data_i;
  logic       msg_valid_i;
  logic       msg_last_i;
  logic       msg_ready_o;
  logic [7:0] data_o;
  logic [2:0] data_ctrl_o;
  logic       ready_i;
  logic       hash_v_i;
  logic [7:0] hash_i;
  logic [7:0] hash_byte_o;
  logic       hash_byte_v_o;
  logic       hash_done_o;
  logic       busy_o;
  logic       timeout_o;
  logic       proto_err_o;

  modport master (
    input  msg_data_i, msg_valid_i, msg_last_i, ready_i, hash_v_i, hash_i,
    output msg_ready_o, data_o, data_ctrl_o, hash_byte_o, hash_byte_v_o,
           hash_done_o, busy_o, timeout_o, proto_err_o
  );

  modport slave (
    output msg_data_i, msg_valid_i, msg_last_i, ready_i, hash_v_i, hash_i,
    input  msg_ready_o, data_o, data_ctrl_o, hash_byte_o, hash_byte_v_o,
           hash_done_o, busy_o, timeout_o, proto_err_o
  );
endinterface

// File: rtl/blake2_bus_host_sync2.sv
// Width-W two-flop synchronizer, asynchronously cleared to zero.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_async,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/blake2_bus_host.sv
// Host end of the BLAKE2 parallel bus: sends a message with stop-and-wait
// pacing, then collects the digest and re-emits it as a byte stream.
module blake2_bus_host
  import blake2_bus_pkg::*;
#(
  parameter int HASH_BYTES     = BLAKE2S_HASH_BYTES,
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 1048575
) (
  input logic              clk,
  input logic              rst_async,
  blake2_bus_host_if.master bus
);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int HC_W  = $clog2(HASH_BYTES + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
  localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(HASH_BYTES - 1);

  state_t state, state_nxt;

  logic       ready_s, hash_v_s;
  logic [7:0] hash_s;

  sync2 #(.W(10)) u_sync (
    .clk      (clk),
    .rst_async(rst_async),
    .d        ({bus.ready_i, bus.hash_v_i, bus.hash_i}),
    .q        ({ready_s, hash_v_s, hash_s})
  );

  logic [GAP_W-1:0] gap_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [HC_W-1:0]  hash_cnt;
  logic [7:0]       data_q;
  logic [2:0]       ctrl_q;
  logic             last_sent;
  logic [7:0]       hbyte_q;
  logic             hbyte_v_q, done_q, timeout_q, perr_q;

  logic gap_expired, msg_ready, accept, gap_end;
  logic hash_take, hash_final, to_fire;

  // The bus stays idle for GAP_CYCLES cycles after each pulse: GAP covers all
  // but the last one, which is the ARM cycle where the next byte is taken.
  assign gap_expired = (gap_cnt == '0);
  assign gap_end     = (gap_cnt <= GAP_W'(1));
  assign msg_ready   = ((state == IDLE) || (state == ARM)) && ready_s && gap_expired;
  assign accept      = msg_ready && bus.msg_valid_i;
  assign hash_take   = (state == WAIT_HASH) && hash_v_s;
  assign hash_final  = hash_take && (hash_cnt == HC_LAST);
  assign to_fire     = (to_cnt == TO_LAST) &&
                       (((state == ARM) && !ready_s) ||
                        ((state == WAIT_HASH) && !hash_v_s));

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept) state_nxt = SEND;
      SEND:      state_nxt = GAP;
      GAP:       if (gap_end) state_nxt = last_sent ? WAIT_HASH : ARM;
      ARM: begin
        if (accept)       state_nxt = SEND;
        else if (to_fire) state_nxt = IDLE;
      end
      WAIT_HASH: if (hash_final || to_fire) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      gap_cnt   <= '0;
      to_cnt    <= '0;
      hash_cnt  <= '0;
      data_q    <= '0;
      ctrl_q    <= '0;
      last_sent <= 1'b0;
      hbyte_q   <= '0;
      hbyte_v_q <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      hbyte_v_q <= 1'b0;
      done_q    <= 1'b0;
      case (state)
        SEND: begin
          ctrl_q  <= '0;
          gap_cnt <= GAP_LOAD;
        end
        GAP: begin
          gap_cnt <= gap_end ? '0 : gap_cnt - GAP_W'(1);
          if (gap_end) begin
            to_cnt   <= '0;
            hash_cnt <= '0;
          end
        end
        ARM: if (!ready_s) to_cnt <= to_cnt + TO_W'(1);
        WAIT_HASH: begin
          if (hash_take) begin
            hbyte_q   <= hash_s;
            hbyte_v_q <= 1'b1;
            done_q    <= hash_final;
            hash_cnt  <= hash_cnt + HC_W'(1);
            to_cnt    <= '0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: ;
      endcase
      if (accept) begin
        data_q    <= bus.msg_data_i;
        ctrl_q    <= make_ctrl(state == IDLE, bus.msg_last_i);
        last_sent <= bus.msg_last_i;
      end
      if (accept && (state == IDLE)) begin
        timeout_q <= 1'b0;
        perr_q    <= 1'b0;
      end
      if (to_fire) timeout_q <= 1'b1;
      // A digest byte outside WAIT_HASH is dropped but flagged.
      if (hash_v_s && (state != WAIT_HASH)) perr_q <= 1'b1;
    end
  end

  assign bus.msg_ready_o   = msg_ready;
  assign bus.data_o        = data_q;
  assign bus.data_ctrl_o   = ctrl_q;
  assign bus.hash_byte_o   = hbyte_q;
  assign bus.hash_byte_v_o = hbyte_v_q;
  assign bus.hash_done_o   = done_q;
  assign bus.busy_o        = (state != IDLE);
  assign bus.timeout_o     = timeout_q;
  assign bus.proto_err_o   = perr_q;

endmodule
